// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
//   - FSM state encoding (HALT exists only when CTRL_ILLEGAL_TRAP_EN is defined)
//   - instruction class produced by opcode_decoder
//   - opcode constants for instr[18:14] and the illegal-opcode test
//   - register-file write-data select and PC-source select encodings
// Build option: CTRL_ILLEGAL_TRAP_EN adds the HALT state.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
`ifdef CTRL_ILLEGAL_TRAP_EN
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
`else
        ST_WB    = 3'd3
`endif
    } state_e;

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_SHIFT   = 4'd2,
        CLS_LDM     = 4'd3,
        CLS_STM     = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JMP     = 4'd6,
        CLS_JSB     = 4'd7,
        CLS_RET     = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_e;

    localparam logic [4:0] OP_LDM = 5'b10000;
    localparam logic [4:0] OP_STM = 5'b10001;
    localparam logic [4:0] OP_JMP = 5'b11100;
    localparam logic [4:0] OP_JSB = 5'b11101;
    localparam logic [4:0] OP_RET = 5'b11110;

    // Branch condition codes, instr[15:14]
    localparam logic [1:0] CC_BZ  = 2'b00;
    localparam logic [1:0] CC_BNZ = 2'b01;
    localparam logic [1:0] CC_BC  = 2'b10;
    localparam logic [1:0] CC_BNC = 2'b11;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_SHRO = 2'b01;
    localparam logic [1:0] WD_DMEM = 2'b10;

    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_DISP = 2'b01;
    localparam logic [1:0] PC_ABS  = 2'b10;

    // Illegal opcodes: 1001x and 11111
    function automatic logic is_illegal_op(input logic [4:0] op);
        return (op[4:1] == 4'b1001) || (op == 5'b11111);
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational decode of instr[18:14] into an instruction
// class and the branch condition code.
// Ports:
//   opcode       in  5  instr[18:14]
//   instr_class  out    decoded class (instr_class_e)
//   branch_cond  out 2  condition code for branches, 0 otherwise
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_e instr_class,
    output logic [1:0]   branch_cond
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        branch_cond = 2'b00;
        if (is_illegal_op(opcode)) begin
            instr_class = CLS_ILLEGAL;
        end else if (opcode[4:3] == 2'b00) begin
            instr_class = CLS_ALU_R;
        end else if (opcode[4:3] == 2'b01) begin
            instr_class = CLS_ALU_I;
        end else if (opcode[4:2] == 3'b110) begin
            instr_class = CLS_SHIFT;
        end else if (opcode[4:2] == 3'b101) begin
            instr_class = CLS_BRANCH;
            branch_cond = opcode[1:0];
        end else if (opcode == OP_LDM) begin
            instr_class = CLS_LDM;
        end else if (opcode == OP_STM) begin
            instr_class = CLS_STM;
        end else if (opcode == OP_JMP) begin
            instr_class = CLS_JMP;
        end else if (opcode == OP_JSB) begin
            instr_class = CLS_JSB;
        end else if (opcode == OP_RET) begin
            instr_class = CLS_RET;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the 19-bit-instruction datapath.
// Sequences FETCH/EXEC/MEM/WB so every instruction retires with one pcEn.
// Parameter MEM_LATENCY (1..15): cycles the data-memory strobe is held in MEM.
// Build option: CTRL_ILLEGAL_TRAP_EN makes illegal opcodes trap into HALT;
// otherwise they retire as NOPs and illegal is tied low.
// Ports:
//   clk, rst (sync, active high), instruction[18:0], COutput, ZOutput
//   pcEn, CEn, ZEn, push, pop, RET, regWrite, DMMemWrite, DMMemRead
//   regFileReadRegister2Select, ALUBInputSelect, ALUOperation[2:0],
//   SHROOperation[1:0], regFileWriteDataSelect[1:0],
//   pc3inputMuxSelectAddress[1:0], illegal
//
// state | meaning
// FETCH | instruction-memory read, no strobes
// EXEC  | decode and execute; single-cycle instructions retire here
// MEM   | data-memory access held for MEM_LATENCY cycles
// WB    | load data written to the register file, PC advances
// HALT  | illegal opcode trapped, only illegal asserted (trap build only)
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] instruction,
    input  logic        COutput,
    input  logic        ZOutput,
    output logic        pcEn,
    output logic        CEn,
    output logic        ZEn,
    output logic        push,
    output logic        pop,
    output logic        RET,
    output logic        regWrite,
    output logic        DMMemWrite,
    output logic        DMMemRead,
    output logic        regFileReadRegister2Select,
    output logic        ALUBInputSelect,
    output logic [2:0]  ALUOperation,
    output logic [1:0]  SHROOperation,
    output logic [1:0]  regFileWriteDataSelect,
    output logic [1:0]  pc3inputMuxSelectAddress,
    output logic        illegal
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_e       state_q, state_d;
    logic [3:0]   lat_cnt_q, lat_cnt_d;
    instr_class_e instr_class;
    logic [1:0]   branch_cond;
    logic         branch_taken;

    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instruction[13:0]};

    opcode_decoder u_decoder (
        .opcode      (instruction[18:14]),
        .instr_class (instr_class),
        .branch_cond (branch_cond)
    );

    always_comb begin
        unique case (branch_cond)
            CC_BZ:   branch_taken = ZOutput;
            CC_BNZ:  branch_taken = ~ZOutput;
            CC_BC:   branch_taken = COutput;
            CC_BNC:  branch_taken = ~COutput;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            lat_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d                    = state_q;
        lat_cnt_d                  = lat_cnt_q;
        pcEn                       = 1'b0;
        CEn                        = 1'b0;
        ZEn                        = 1'b0;
        push                       = 1'b0;
        pop                        = 1'b0;
        RET                        = 1'b0;
        regWrite                   = 1'b0;
        DMMemWrite                 = 1'b0;
        DMMemRead                  = 1'b0;
        regFileReadRegister2Select = 1'b0;
        ALUBInputSelect            = 1'b0;
        ALUOperation               = 3'd0;
        SHROOperation              = 2'd0;
        regFileWriteDataSelect     = WD_ALU;
        pc3inputMuxSelectAddress   = PC_NEXT;
        illegal                    = 1'b0;

        case (state_q)
            ST_FETCH: state_d = ST_EXEC;

            ST_EXEC: begin
                state_d = ST_FETCH;
                case (instr_class)
                    CLS_ALU_R, CLS_ALU_I: begin
                        regWrite     = 1'b1;
                        CEn          = 1'b1;
                        ZEn          = 1'b1;
                        pcEn         = 1'b1;
                        ALUOperation = instruction[16:14];
                        if (instr_class == CLS_ALU_R) begin
                            ALUBInputSelect            = 1'b1;
                            regFileReadRegister2Select = 1'b1;
                        end
                    end
                    CLS_SHIFT: begin
                        regWrite               = 1'b1;
                        pcEn                   = 1'b1;
                        SHROOperation          = instruction[15:14];
                        regFileWriteDataSelect = WD_SHRO;
                    end
                    CLS_LDM: begin
                        DMMemRead = 1'b1;
                        lat_cnt_d = LAT_LOAD;
                        state_d   = ST_MEM;
                    end
                    CLS_STM: begin
                        DMMemWrite = 1'b1;
                        lat_cnt_d  = LAT_LOAD;
                        state_d    = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        pcEn                     = 1'b1;
                        pc3inputMuxSelectAddress = branch_taken ? PC_DISP : PC_NEXT;
                    end
                    CLS_JMP: begin
                        pcEn                     = 1'b1;
                        pc3inputMuxSelectAddress = PC_ABS;
                    end
                    CLS_JSB: begin
                        push                     = 1'b1;
                        pcEn                     = 1'b1;
                        pc3inputMuxSelectAddress = PC_ABS;
                    end
                    CLS_RET: begin
                        pop  = 1'b1;
                        RET  = 1'b1;
                        pcEn = 1'b1;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = ST_HALT;
`else
                        pcEn = 1'b1;
`endif
                    end
                endcase
            end

            ST_MEM: begin
                // The instruction word is held by the datapath until pcEn,
                // so the decoded class still tells load from store here.
                if (instr_class == CLS_LDM) begin
                    DMMemRead = 1'b1;
                end else begin
                    DMMemWrite = 1'b1;
                end
                if (lat_cnt_q == 4'd0) begin
                    if (instr_class == CLS_LDM) begin
                        state_d = ST_WB;
                    end else begin
                        pcEn    = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            ST_WB: begin
                DMMemRead              = 1'b1;
                regWrite               = 1'b1;
                pcEn                   = 1'b1;
                regFileWriteDataSelect = WD_DMEM;
                state_d                = ST_FETCH;
            end

`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_HALT: illegal = 1'b1;
`endif

            default: state_d = ST_FETCH;
        endcase

        // Outputs are silenced while rst is high so that no write or PC
        // update completes on the reset edge.
        if (rst) begin
            pcEn                       = 1'b0;
            CEn                        = 1'b0;
            ZEn                        = 1'b0;
            push                       = 1'b0;
            pop                        = 1'b0;
            RET                        = 1'b0;
            regWrite                   = 1'b0;
            DMMemWrite                 = 1'b0;
            DMMemRead                  = 1'b0;
            regFileReadRegister2Select = 1'b0;
            ALUBInputSelect            = 1'b0;
            ALUOperation               = 3'd0;
            SHROOperation              = 2'd0;
            regFileWriteDataSelect     = WD_ALU;
            pc3inputMuxSelectAddress   = PC_NEXT;
            illegal                    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases followed by random
// instructions, each compared cycle by cycle with a trace built from the
// instruction-level behaviour (cycle counts and strobes per class).
module tb_multicycle_controller;

    localparam int LAT = 3;

    typedef struct packed {
        logic       pc_en;
        logic       c_en;
        logic       z_en;
        logic       push;
        logic       pop;
        logic       ret;
        logic       reg_write;
        logic       dm_write;
        logic       dm_read;
        logic       rd2_sel;
        logic       alub_sel;
        logic [2:0] alu_op;
        logic [1:0] shro_op;
        logic [1:0] wd_sel;
        logic [1:0] pc_sel;
        logic       illegal;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] instruction = '0;
    logic        c_flag = 1'b0;
    logic        z_flag = 1'b0;
    out_t        dut_out;

    int n_checks = 0;
    int n_pass   = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_LATENCY(LAT)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .instruction                (instruction),
        .COutput                    (c_flag),
        .ZOutput                    (z_flag),
        .pcEn                       (dut_out.pc_en),
        .CEn                        (dut_out.c_en),
        .ZEn                        (dut_out.z_en),
        .push                       (dut_out.push),
        .pop                        (dut_out.pop),
        .RET                        (dut_out.ret),
        .regWrite                   (dut_out.reg_write),
        .DMMemWrite                 (dut_out.dm_write),
        .DMMemRead                  (dut_out.dm_read),
        .regFileReadRegister2Select (dut_out.rd2_sel),
        .ALUBInputSelect            (dut_out.alub_sel),
        .ALUOperation               (dut_out.alu_op),
        .SHROOperation              (dut_out.shro_op),
        .regFileWriteDataSelect     (dut_out.wd_sel),
        .pc3inputMuxSelectAddress   (dut_out.pc_sel),
        .illegal                    (dut_out.illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Expected per-cycle outputs of one instruction, starting at FETCH.
    task automatic build_trace(input logic [18:0] ins, input logic c, input logic z);
        out_t       o;
        logic [4:0] op;
        logic       taken;
        op = ins[18:14];
        exp_q.delete();
        o = '0;
        exp_q.push_back(o);
        if (op[4:3] == 2'b00 || op[4:3] == 2'b01) begin
            o.reg_write = 1'b1;
            o.c_en      = 1'b1;
            o.z_en      = 1'b1;
            o.pc_en     = 1'b1;
            o.alu_op    = ins[16:14];
            o.alub_sel  = (op[4:3] == 2'b00);
            o.rd2_sel   = (op[4:3] == 2'b00);
            exp_q.push_back(o);
        end else if (op[4:2] == 3'b110) begin
            o.reg_write = 1'b1;
            o.pc_en     = 1'b1;
            o.wd_sel    = 2'b01;
            o.shro_op   = ins[15:14];
            exp_q.push_back(o);
        end else if (op == 5'b10000) begin
            o.dm_read = 1'b1;
            for (int i = 0; i < LAT + 1; i++) exp_q.push_back(o);
            o.reg_write = 1'b1;
            o.wd_sel    = 2'b10;
            o.pc_en     = 1'b1;
            exp_q.push_back(o);
        end else if (op == 5'b10001) begin
            o.dm_write = 1'b1;
            for (int i = 0; i < LAT; i++) exp_q.push_back(o);
            o.pc_en = 1'b1;
            exp_q.push_back(o);
        end else if (op[4:2] == 3'b101) begin
            case (op[1:0])
                2'b00:   taken = z;
                2'b01:   taken = !z;
                2'b10:   taken = c;
                default: taken = !c;
            endcase
            o.pc_en  = 1'b1;
            o.pc_sel = taken ? 2'b01 : 2'b00;
            exp_q.push_back(o);
        end else if (op == 5'b11100 || op == 5'b11101) begin
            o.pc_en  = 1'b1;
            o.push   = (op == 5'b11101);
            o.pc_sel = 2'b10;
            exp_q.push_back(o);
        end else if (op == 5'b11110) begin
            o.pop   = 1'b1;
            o.ret   = 1'b1;
            o.pc_en = 1'b1;
            exp_q.push_back(o);
        end else begin
            o.pc_en = 1'b1;
            exp_q.push_back(o);
        end
    endtask

    // Called #1 after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [18:0] ins, input logic c, input logic z, input string tag);
        instruction = ins;
        c_flag      = c;
        z_flag      = z;
        build_trace(ins, c, z);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("%s.cyc%0d", tag, i), 32'(dut_out), 32'(exp_q[i]));
            check($sformatf("%s.push_pop%0d", tag, i), 32'(dut_out.push & dut_out.pop), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs", 32'(dut_out), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    function automatic logic is_illegal(input logic [4:0] op);
        return (op[4:1] == 4'b1001) || (op == 5'b11111);
    endfunction

    initial begin
        logic [18:0] ins;
        out_t        o;

        @(posedge clk);
        #1;
        do_reset();

        run_instr({5'b00000, 14'h0123}, 1'b0, 1'b0, "add");
        run_instr({5'b01011, 14'h00A5}, 1'b1, 1'b0, "alu_imm");
        run_instr({5'b11010, 14'h0011}, 1'b1, 1'b1, "shift");
        run_instr({5'b10100, 6'd0, 8'hFC}, 1'b0, 1'b1, "bz_taken");
        run_instr({5'b10100, 6'd0, 8'hFC}, 1'b0, 1'b0, "bz_not");
        run_instr({5'b10111, 6'd0, 8'h10}, 1'b0, 1'b1, "bnc_taken");
        run_instr({5'b10000, 14'h0842}, 1'b0, 1'b0, "ldm");
        run_instr({5'b10001, 14'h1842}, 1'b0, 1'b0, "stm");
        run_instr({5'b11101, 2'b00, 12'h123}, 1'b0, 1'b0, "jsb");
        run_instr({5'b11110, 14'h0000}, 1'b0, 1'b0, "ret");
        run_instr({5'b11100, 2'b00, 12'h3FF}, 1'b0, 1'b0, "jmp");

        // Reset during MEM of a store: abandoned with no write or pcEn.
        instruction = {5'b10001, 14'h0777};
        o = '0;
        @(negedge clk);
        check("rst_mem.fetch", 32'(dut_out), 32'(o));
        @(posedge clk);
        #1;
        o.dm_write = 1'b1;
        @(negedge clk);
        check("rst_mem.exec", 32'(dut_out), 32'(o));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mem.mem1", 32'(dut_out), 32'(o));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem.in_reset", 32'(dut_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr({5'b00111, 14'h0000}, 1'b0, 1'b0, "after_rst");
        run_instr({5'b10001, 14'h0001}, 1'b0, 1'b0, "stm_after_rst");

`ifdef CTRL_ILLEGAL_TRAP_EN
        instruction = {5'b11111, 14'h0000};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("trap.pre%0d", i), 32'(dut_out), 32'd0);
            @(posedge clk);
            #1;
        end
        o = '0;
        o.illegal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("trap.halt%0d", i), 32'(dut_out), 32'(o));
            @(posedge clk);
            #1;
        end
        do_reset();
`else
        run_instr({5'b11111, 14'h0000}, 1'b0, 1'b0, "illegal_nop");
        run_instr({5'b10011, 14'h0055}, 1'b1, 1'b1, "illegal_nop2");
`endif

        for (int n = 0; n < 200; n++) begin
            ins = 19'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
            while (is_illegal(ins[18:14])) ins = 19'($urandom);
`endif
            run_instr(ins, 1'($urandom), 1'($urandom), $sformatf("rnd%0d_op%05b", n, ins[18:14]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
